// File: rtl/axis_value_sender.sv
// ---------------------------------------------------------------------------
// axis_value_sender
//
// Samples a parallel value bus and emits it as an AXI4-Stream master beat
// whenever the value changes (if enabled) and/or a programmable period
// expires. Back-pressure is honoured: while a beat is stalled the beat is
// held stable, and further triggers are merged into a single pending send
// that carries whatever value is on the bus at the moment it is handed over.
//
// Ports
//   aclk            clock, all logic on the rising edge
//   aresetn         synchronous active-low reset
//   cfg_period      periodic send interval in cycles, 0 = on-change only
//   cfg_on_change   1 = also send whenever data differs from last cycle
//   data            value to transmit
//   m_axis_tdata    stream data
//   m_axis_tvalid   stream valid
//   m_axis_tready   stream ready
//   sts_sent        number of completed handshakes, wraps
//   sts_coalesced   number of triggers merged into an already pending send
// ---------------------------------------------------------------------------
module axis_value_sender #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [CNTR_WIDTH-1:0]       cfg_period,
   input  logic                        cfg_on_change,
   input  logic [AXIS_TDATA_WIDTH-1:0] data,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [31:0]                 sts_sent,
   output logic [31:0]                 sts_coalesced
);

   localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);
   localparam logic [31:0]           STS_ONE  = 32'd1;

   // IDLE: nothing on the bus. SEND: a beat is being offered.
   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t state;
   state_t state_next;

   logic [AXIS_TDATA_WIDTH-1:0] prev;
   logic [CNTR_WIDTH-1:0]       cnt;
   logic                        pending;

   logic chg;
   logic tick;
   logic trig;

   // Control strobes from the output decoder into the datapath registers.
   logic load_data;
   logic inc_sent;
   logic inc_coal;
   logic set_pending;
   logic clr_pending;

   // A change is only seen relative to the value registered one cycle ago.
   // The tick fires on the last count of the period; the ">=" (rather than
   // "==") makes a lowered period take effect on the very next cycle instead
   // of waiting for the counter to wrap.
   assign chg  = cfg_on_change & (data != prev);
   assign tick = (cfg_period != '0) && (cnt >= (cfg_period - CNT_ONE));
   assign trig = chg | tick;

   // tvalid is purely a function of the registered state, so it never
   // depends combinationally on tready.
   assign m_axis_tvalid = (state == SEND);

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: leave SEND only when the beat is accepted and there
   // is nothing further to send.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (trig) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (m_axis_tready && !(trig || pending)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decoder. On acceptance with more work to do the next value is
   // loaded straight away so beats run back-to-back. A trigger that meets an
   // already pending send (stalled or at the handshake) counts as coalesced.
   always_comb begin
      load_data   = 1'b0;
      inc_sent    = 1'b0;
      inc_coal    = 1'b0;
      set_pending = 1'b0;
      clr_pending = 1'b0;
      case (state)
         IDLE: begin
            load_data = trig;
         end
         SEND: begin
            if (m_axis_tready) begin
               inc_sent = 1'b1;
               if (trig || pending) begin
                  load_data   = 1'b1;
                  clr_pending = 1'b1;
               end
               inc_coal = trig & pending;
            end else if (trig) begin
               if (pending) begin
                  inc_coal = 1'b1;
               end else begin
                  set_pending = 1'b1;
               end
            end
         end
         default: begin
            load_data = 1'b0;
         end
      endcase
   end

   // Previous-value register used for change detection.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         prev <= '0;
      end else begin
         prev <= data;
      end
   end

   // Free-running period counter; it keeps counting through stalls and is
   // parked at zero while periodic sending is disabled.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         cnt <= '0;
      end else if (cfg_period == '0 || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Stream data, pending flag and status counters. tdata only moves when a
   // new beat is loaded, which keeps it stable while the consumer stalls.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         pending       <= 1'b0;
         sts_sent      <= '0;
         sts_coalesced <= '0;
      end else begin
         if (load_data) begin
            m_axis_tdata <= data;
         end
         if (set_pending) begin
            pending <= 1'b1;
         end else if (clr_pending) begin
            pending <= 1'b0;
         end
         if (inc_sent) begin
            sts_sent <= sts_sent + STS_ONE;
         end
         if (inc_coal) begin
            sts_coalesced <= sts_coalesced + STS_ONE;
         end
      end
   end

endmodule
